// File: rtl/colour_lookup_arbiter_pkg.sv
// Shared types and constants for the colour lookup arbiter.
// Contents: FSM state enum, 3-bit colour codes, and the 24-bit RGB words the
// colour memory holds at each code.
package colour_lookup_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;

endpackage

// File: rtl/colour_lookup_arbiter_rr_picker.sv
// Combinational round-robin priority selector.
// Ports: i_req (request levels), i_rr_ptr (highest-priority index),
//        o_gnt_vld (some request is set), o_gnt_idx (winning index).
module rr_picker
  import colour_lookup_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_rr_ptr,
  output logic             o_gnt_vld,
  output logic [1:0]       o_gnt_idx
);

  logic [2:0] w_sum;

  // Walk offsets from farthest to nearest so the candidate closest to
  // i_rr_ptr (upward, wrapping) is the last one written and therefore wins.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = 2'd0;
    w_sum     = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_rr_ptr} + 3'(k);
      if (w_sum >= 3'(N_REQ)) begin
        w_sum = w_sum - 3'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (w_sum == 3'(j) && i_req[j]) begin
          o_gnt_vld = 1'b1;
          o_gnt_idx = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/colour_lookup_arbiter.sv
// Round-robin arbiter sharing one 8-entry colour memory between N_REQ requesters.
// Ports: i_clk/i_rst (async active-high), i_enable, i_req, i_colour in;
//        o_ack pulse, o_rgb, o_rsp_id out; o_mem_* / i_mem_rdata to the memory core.
module colour_lookup_arbiter
  import colour_lookup_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [3*N_REQ-1:0]   i_colour,
  output logic [N_REQ-1:0]     o_ack,
  output logic [23:0]          o_rgb,
  output logic [1:0]           o_rsp_id,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [2:0]           o_mem_addr,
  output logic [23:0]          o_mem_wdata,
  input  logic [23:0]          i_mem_rdata
);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic [23:0]      r_rgb, w_rgb_nxt;
  logic [1:0]       r_rsp_id, w_rsp_id_nxt;
  logic             r_mem_en, w_mem_en_nxt;
  logic [2:0]       r_mem_addr, w_mem_addr_nxt;

  logic             w_gnt_vld;
  logic [1:0]       w_gnt_idx;
  logic [2:0]       w_colour;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req     (i_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  // Colour code of the requester the picker would grant this cycle.
  always_comb begin
    w_colour = 3'd0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_gnt_idx == 2'(j)) begin
        w_colour = i_colour[3*j +: 3];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt      = r_cnt;
    w_ack_nxt      = '0;
    w_rgb_nxt      = r_rgb;
    w_rsp_id_nxt   = r_rsp_id;
    w_mem_en_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      IDLE: begin
        if (i_enable && w_gnt_vld) begin
          w_gnt_nxt      = w_gnt_idx;
          w_mem_addr_nxt = w_colour;
          w_mem_en_nxt   = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_nxt   = 2'(MEM_LAT - 1);
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else begin
          w_rgb_nxt    = i_mem_rdata;
          w_rsp_id_nxt = r_gnt;
          for (int j = 0; j < N_REQ; j++) begin
            if (r_gnt == 2'(j)) begin
              w_ack_nxt[j] = 1'b1;
            end
          end
          w_rr_ptr_nxt = (r_gnt == 2'(N_REQ - 1)) ? 2'd0 : r_gnt + 2'd1;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        // Ack is only visible here; going back through IDLE for a full
        // cycle lets the requester drop req before it is sampled again.
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_gnt      <= 2'd0;
      r_rr_ptr   <= 2'd0;
      r_cnt      <= 2'd0;
      r_ack      <= '0;
      r_rgb      <= 24'h000000;
      r_rsp_id   <= 2'd0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_rgb      <= w_rgb_nxt;
      r_rsp_id   <= w_rsp_id_nxt;
      r_mem_en   <= w_mem_en_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  assign o_ack       = r_ack;
  assign o_rgb       = r_rgb;
  assign o_rsp_id    = r_rsp_id;
  assign o_mem_en    = r_mem_en;
  assign o_mem_addr  = r_mem_addr;
  // Read-only client of the memory.
  assign o_mem_we    = 1'b0;
  assign o_mem_wdata = 24'h000000;

endmodule

// File: tb/tb_colour_lookup_arbiter.sv
module tb_colour_lookup_arbiter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  req;
  logic [5:0]  colour;
  logic [1:0]  ack;
  logic [23:0] rgb;
  logic [1:0]  rsp_id;
  logic        mem_en, mem_we;
  logic [2:0]  mem_addr;
  logic [23:0] mem_wdata, mem_rdata;

  logic [1:0]  req3;
  logic [5:0]  colour3;
  logic [1:0]  ack3;
  logic [23:0] rgb3;
  logic [1:0]  rsp_id3;
  logic        mem_en3, mem_we3;
  logic [2:0]  mem_addr3;
  logic [23:0] mem_wdata3, mem_rdata3;
  logic [23:0] m3_s0, m3_s1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0, en3_cnt = 0;
  logic [2:0] last_addr = 3'd0, last_addr3 = 3'd0;
  logic we_bad = 1'b0;
  int ack_id_q[$];
  int ack_cyc_q[$];
  logic [23:0] ack_rgb_q[$];

  colour_lookup_arbiter #(.N_REQ(2), .MEM_LAT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_req(req), .i_colour(colour),
    .o_ack(ack), .o_rgb(rgb), .o_rsp_id(rsp_id), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  colour_lookup_arbiter #(.N_REQ(2), .MEM_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_enable(1'b1), .i_req(req3), .i_colour(colour3),
    .o_ack(ack3), .o_rgb(rgb3), .o_rsp_id(rsp_id3), .o_mem_en(mem_en3), .o_mem_we(mem_we3),
    .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom(input logic [2:0] c);
    case (c)
      3'd0: rom = 24'h000000;
      3'd1: rom = 24'h0000FF;
      3'd2: rom = 24'h00FF00;
      3'd3: rom = 24'h00FFFF;
      3'd4: rom = 24'hFF0000;
      3'd5: rom = 24'hFF00FF;
      3'd6: rom = 24'hFFFF00;
      default: rom = 24'hFFFFFF;
    endcase
  endfunction

  // Colour memory models: one registered stage, plus two more for MEM_LAT=3.
  initial begin
    mem_rdata = 24'h0; m3_s0 = 24'h0; m3_s1 = 24'h0; mem_rdata3 = 24'h0;
  end
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom(mem_addr);
    if (mem_en3) m3_s0 <= rom(mem_addr3);
    m3_s1 <= m3_s0;
    mem_rdata3 <= m3_s1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ack != 2'b00) begin
      ack_id_q.push_back(int'(rsp_id));
      ack_cyc_q.push_back(cyc);
      ack_rgb_q.push_back(rgb);
      chk("ack_vs_rsp_id", 32'(ack), 32'(2'b01 << rsp_id));
    end
    if (mem_en) begin en_cnt++; last_addr = mem_addr; end
    if (mem_en3) begin en3_cnt++; last_addr3 = mem_addr3; end
    if (mem_we || mem_we3 || mem_wdata != 24'h0 || mem_wdata3 != 24'h0) we_bad = 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; req3 = 2'b00; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ack_id_q.delete(); ack_cyc_q.delete(); ack_rgb_q.delete();
  endtask

  // Count edges from now until an ack is seen; lat=-1 if the budget expires.
  task automatic wait_ack(input int which, input int lim, output int lat);
    lat = -1;
    for (int n = 1; n <= lim; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((which == 0 ? ack : ack3) != 2'b00) begin
        lat = n;
        break;
      end
    end
  endtask

  // Requesters in `want` hold req until acked, then drop on the next edge.
  task automatic serve(input logic [1:0] want, input int lim);
    logic [1:0] pend, seen;
    pend = want;
    req = req | want;
    for (int n = 0; n < lim && pend != 2'b00; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != 2'b00) begin
        seen = ack;
        pend = pend & ~seen;
        @(posedge clk);
        #1 req = req & ~seen;
      end
    end
    if (pend != 2'b00) chk("serve_timeout", 32'(pend), 32'd0);
  endtask

  int lat, start, e0, qs, min_gap;
  logic drop0;

  initial begin
    rst = 1'b1; enable = 1'b1; req = 2'b00; colour = 6'd0; req3 = 2'b00; colour3 = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // 1: single request, RED
    do_reset();
    e0 = en_cnt;
    colour = {3'd0, 3'd4}; req = 2'b01;
    wait_ack(0, 20, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_ack", 32'(ack), 32'b01);
    chk("t1_rgb", 32'(rgb), 32'hFF0000);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_en_pulses", 32'(en_cnt - e0), 32'd1);
    chk("t1_addr", 32'(last_addr), 32'd4);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    chk("t1_ack_one_cycle", 32'(ack), 32'd0);
    chk("t1_rgb_held", 32'(rgb), 32'hFF0000);

    // 2: simultaneous requests, BLUE / YELLOW, twice
    do_reset();
    start = cyc;
    colour = {3'd6, 3'd1};
    serve(2'b11, 40);
    serve(2'b11, 40);
    chk("t2_count", 32'(ack_id_q.size()), 32'd4);
    if (ack_id_q.size() == 4) begin
      chk("t2_first_lat", 32'(ack_cyc_q[0] - start), 32'd3);
      chk("t2_gap", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd4);
      chk("t2_id0", 32'(ack_id_q[0]), 32'd0);
      chk("t2_id1", 32'(ack_id_q[1]), 32'd1);
      chk("t2_id2", 32'(ack_id_q[2]), 32'd0);
      chk("t2_id3", 32'(ack_id_q[3]), 32'd1);
      chk("t2_rgb0", 32'(ack_rgb_q[0]), 32'h0000FF);
      chk("t2_rgb1", 32'(ack_rgb_q[1]), 32'hFFFF00);
    end

    // 3: requester 1 continuous (GREEN), requester 0 once (CYAN)
    do_reset();
    e0 = en_cnt;
    drop0 = 1'b0;
    colour = {3'd2, 3'd3}; req = 2'b10;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (drop0) begin req[0] = 1'b0; drop0 = 1'b0; end
      if (c == 1) req[0] = 1'b1;
      @(negedge clk);
      if (ack[0]) drop0 = 1'b1;
    end
    req = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    chk("t3_count", 32'(ack_id_q.size()), 32'd6);
    chk("t3_grants", 32'(en_cnt - e0), 32'd6);
    if (ack_id_q.size() >= 2) begin
      chk("t3_id0", 32'(ack_id_q[0]), 32'd1);
      chk("t3_id1_req0_served", 32'(ack_id_q[1]), 32'd0);
      chk("t3_rgb0", 32'(ack_rgb_q[0]), 32'h00FF00);
      chk("t3_rgb1", 32'(ack_rgb_q[1]), 32'h00FFFF);
      min_gap = 1000;
      for (int i = 1; i < ack_cyc_q.size(); i++)
        if (ack_cyc_q[i] - ack_cyc_q[i-1] < min_gap) min_gap = ack_cyc_q[i] - ack_cyc_q[i-1];
      chk("t3_min_gap", 32'(min_gap), 32'd4);
    end

    // 4: enable gating (MAGENTA), then enable dropped during WAIT (GREEN)
    do_reset();
    e0 = en_cnt;
    enable = 1'b0; colour = {3'd0, 3'd5}; req = 2'b01;
    repeat (10) begin @(posedge clk); #1; end
    chk("t4_no_grant", 32'(en_cnt - e0), 32'd0);
    chk("t4_no_ack", 32'(ack_id_q.size()), 32'd0);
    enable = 1'b1;
    wait_ack(0, 20, lat);
    chk("t4_latency", 32'(lat), 32'd3);
    chk("t4_rgb", 32'(rgb), 32'hFF00FF);
    @(posedge clk); #1 req = 2'b00;
    colour = {3'd0, 3'd2}; req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1 enable = 1'b0;
    wait_ack(0, 20, lat);
    chk("t4_wait_latency", 32'(lat), 32'd1);
    chk("t4_wait_rgb", 32'(rgb), 32'h00FF00);
    @(posedge clk); #1 req = 2'b00; enable = 1'b1;

    // 5: reset during WAIT of requester 1's access
    do_reset();
    colour = {3'd6, 3'd1};
    serve(2'b01, 20);
    req = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    qs = ack_id_q.size();
    @(negedge clk);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_rgb", 32'(rgb), 32'd0);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; req = 2'b00;
    chk("t5_no_ack", 32'(ack_id_q.size()), 32'(qs));
    colour = {3'd6, 3'd4};
    serve(2'b11, 40);
    chk("t5_count", 32'(ack_id_q.size()), 32'(qs + 2));
    if (ack_id_q.size() > qs) begin
      chk("t5_first_id", 32'(ack_id_q[qs]), 32'd0);
      chk("t5_first_rgb", 32'(ack_rgb_q[qs]), 32'hFF0000);
    end

    // 6: MEM_LAT=3 instance, WHITE
    do_reset();
    e0 = en3_cnt;
    colour3 = {3'd0, 3'd7}; req3 = 2'b01;
    wait_ack(1, 20, lat);
    chk("t6_latency", 32'(lat), 32'd5);
    chk("t6_ack", 32'(ack3), 32'b01);
    chk("t6_rgb", 32'(rgb3), 32'hFFFFFF);
    chk("t6_rsp_id", 32'(rsp_id3), 32'd0);
    chk("t6_en_pulses", 32'(en3_cnt - e0), 32'd1);
    chk("t6_addr", 32'(last_addr3), 32'd7);
    @(posedge clk); #1 req3 = 2'b00;
    repeat (4) @(posedge clk);
    chk("we_wdata_zero", 32'(we_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
